sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single-port SRAM controller between two Avalon-MM-style requesters: port 0 (video scanout, latency-critical) and port 1 (rasterizer/CPU bulk traffic).
- Port 0 has fixed priority. A starvation counter guarantees port 1 forward progress.
- Issues at most one command to the controller per slot and returns read data to the originating port with a valid strobe.
- Sits between the requester fabric and sram_controller, driving its mm_* command port.

Parameters:
- READ_LATENCY, 2: a read asserted on mm_read in cycle N has mm_readdata valid in cycle N+READ_LATENCY. The controller accepts no command in cycles N+1..N+READ_LATENCY-1. Legal values are 1..4.
- STARVE_LIMIT, 4: number of consecutive port-0 grants, while port 1 is requesting, after which port 1 is forced one grant. Legal values are 1..15.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- p0_address, input, 20: port 0 word address.
- p0_read, input, 1: port 0 read request.
- p0_write, input, 1: port 0 write request.
- p0_writedata, input, 16: port 0 write data.
- p0_waitrequest, output, 1: port 0 stall. The request is accepted in a cycle where it is low.
- p0_readdata, output, 16: port 0 read data.
- p0_readdatavalid, output, 1: port 0 read data strobe.
- p1_address, p1_read, p1_write, p1_writedata, p1_waitrequest, p1_readdata, p1_readdatavalid: same as port 0, for port 1.
- mm_address, output, 20: controller address.
- mm_read, output, 1: controller read command.
- mm_write, output, 1: controller write command.
- mm_writedata, output, 16: controller write data.
- mm_readdata, input, 16: controller read data.

Behaviour:
- Reset values, applied on the first edge with reset high and held while reset is high:
  - mm_read = 0, mm_write = 0, mm_address = 0, mm_writedata = 0.
  - pK_readdatavalid = 0, pK_readdata = 0.
  - pK_waitrequest = 1 (combinationally, while reset is high).
  - Starvation counter = 0. FSM = IDLE. Any in-flight read is discarded and no readdatavalid is produced for it.
- Requester protocol: a requester holds address/read/write/writedata stable until it sees waitrequest low. pK_waitrequest is combinational from the FSM state, the starvation counter and the request inputs.
- FSM states: IDLE and BUSY.
  - IDLE: the arbiter picks a winner among requesting ports, drives mm_* combinationally from that port, and drives the winner's waitrequest low. The loser's waitrequest stays high.
  - A write grant stays in IDLE. The next command can issue in the following cycle.
  - A read grant goes to BUSY and loads the busy counter with READ_LATENCY-1. If READ_LATENCY = 1, it stays in IDLE.
  - BUSY: mm_read = mm_write = 0 and both waitrequests are high. The counter decrements each cycle, and the FSM returns to IDLE when the counter reaches 1→0 (exactly READ_LATENCY-1 BUSY cycles).
- Read return pipeline:
  - A shift register of depth READ_LATENCY carries {valid, port id}.
  - In cycle N+READ_LATENCY, mm_readdata is registered into pK_readdata of the tagged port.
  - pK_readdatavalid pulses for exactly one cycle, N+READ_LATENCY+1.
  - The other port's readdata holds its previous value.
- Arbitration:
  - Only port 0 requesting: port 0 is granted.
  - Only port 1 requesting: port 1 is granted.
  - Both requesting and starvation counter < STARVE_LIMIT: port 0 is granted and the counter increments.
  - Both requesting and counter == STARVE_LIMIT: port 1 is granted.
  - Any port-1 grant clears the counter. A port-0 grant while port 1 is idle also clears it.
- Simultaneous read and write on the same port is a protocol violation. The arbiter treats it as a read, suppresses the write, and acknowledges once.
- mm_address and mm_writedata hold their last granted values when no command is issued. The mm_read/mm_write strobes are never high together.
- A throughput of one command per cycle is sustained for back-to-back writes. Reads sustain one per READ_LATENCY cycles.

Test Plan:
- Reset hold: hold reset for 3 cycles with p0_read high → p0_waitrequest = 1, mm_read = 0, and no readdatavalid throughout.
- Port-0 write/read round trip: p0 writes 0x01234 = 0xAAAA, then reads 0x01234.
  - The write is issued in cycle 1 with waitrequest low.
  - The read is issued in cycle 2.
  - With READ_LATENCY = 2, p0_readdata = 0xAAAA and p0_readdatavalid is high in cycle 5 only.
  - No command is issued in cycle 3.
- Priority and starvation: with STARVE_LIMIT = 4, both ports request continuous writes (p0 to 0x00010+, p1 to 0x00100) → grant sequence p0,p0,p0,p0,p1,p0,p0,p0,p0,p1.
- Tag routing: p1 reads 0x01235 (preloaded 0x5555), then p0 reads 0x01234 (0xAAAA) back-to-back → only p1_readdatavalid is high with 0x5555, then 2 cycles later only p0_readdatavalid is high with 0xAAAA.
- Reset mid-read: assert reset one cycle after p0's read is issued → no p0_readdatavalid pulse. After release, the FSM is in IDLE and a new p1 write is granted in the first cycle.
- Read+write violation: p1_read and p1_write are both high at 0x00042 → exactly one mm_read, mm_write stays 0, and one p1_readdatavalid pulse.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single-port SRAM controller: fixed priority for
// port 0 (scanout), starvation guard for port 1, tagged read-return pipeline.
module sram_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4,
    localparam int unsigned AW = 20,
    localparam int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [AW-1:0] p0_address,
    input  logic          p0_read,
    input  logic          p0_write,
    input  logic [DW-1:0] p0_writedata,
    output logic          p0_waitrequest,
    output logic [DW-1:0] p0_readdata,
    output logic          p0_readdatavalid,

    input  logic [AW-1:0] p1_address,
    input  logic          p1_read,
    input  logic          p1_write,
    input  logic [DW-1:0] p1_writedata,
    output logic          p1_waitrequest,
    output logic [DW-1:0] p1_readdata,
    output logic          p1_readdatavalid,

    output logic [AW-1:0] mm_address,
    output logic          mm_read,
    output logic          mm_write,
    output logic [DW-1:0] mm_writedata,
    input  logic [DW-1:0] mm_readdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam int unsigned CW = 3;
    localparam int unsigned SW = 4;

    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] busy_q;
    logic [CW-1:0] busy_d;
    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    rd_tag_t       tag_q [READ_LATENCY];
    rd_tag_t       ret_tag;

    logic          req0;
    logic          req1;
    logic          grant0;
    logic          grant1;
    logic          granted;
    logic          sel_read;
    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          ret0;
    logic          ret1;

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    // Port 1 wins only when alone or when port 0 has used up its consecutive-grant budget
    always_comb begin : arbitrate
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && (state_q == IDLE)) begin
            if (req1 && (!req0 || (starve_q == SW'(STARVE_LIMIT)))) begin
                grant1 = 1'b1;
            end else if (req0) begin
                grant0 = 1'b1;
            end
        end
    end

    assign p0_waitrequest = ~grant0;
    assign p1_waitrequest = ~grant1;

    // Read has precedence over a simultaneous write; address/data hold when idle
    always_comb begin : command_mux
        sel_read     = grant1 ? p1_read      : p0_read;
        sel_write    = grant1 ? p1_write     : p0_write;
        sel_addr     = grant1 ? p1_address   : p0_address;
        sel_wdata    = grant1 ? p1_writedata : p0_writedata;
        granted      = grant0 | grant1;
        mm_read      = granted & sel_read;
        mm_write     = granted & sel_write & ~sel_read;
        mm_address   = granted ? sel_addr  : addr_q;
        mm_writedata = granted ? sel_wdata : wdata_q;
    end

    always_comb begin : next_state
        state_d  = state_q;
        busy_d   = busy_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (mm_read && (READ_LATENCY > 1)) begin
                    state_d = BUSY;
                    busy_d  = CW'(READ_LATENCY - 1);
                end
            end
            BUSY: begin
                busy_d = busy_q - CW'(1);
                if (busy_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = '0;
            end
        endcase
        if (grant1) begin
            starve_d = '0;
        end else if (grant0) begin
            starve_d = req1 ? (starve_q + SW'(1)) : '0;
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= '0;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            addr_q   <= mm_address;
            wdata_q  <= mm_writedata;
        end
    end

    assign ret_tag = tag_q[READ_LATENCY-1];
    assign ret0    = ret_tag.vld & ~ret_tag.port;
    assign ret1    = ret_tag.vld &  ret_tag.port;

    // Tag reaches the last stage in the cycle the controller presents the data
    always_ff @(posedge clk) begin : read_return
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            p0_readdata      <= '0;
            p1_readdata      <= '0;
            p0_readdatavalid <= 1'b0;
            p1_readdatavalid <= 1'b0;
        end else begin
            tag_q[0] <= '{vld: mm_read, port: grant1};
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            p0_readdatavalid <= ret0;
            p1_readdatavalid <= ret1;
            if (ret0) begin
                p0_readdata <= mm_readdata;
            end
            if (ret1) begin
                p1_readdata <= mm_readdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the mm_* side, read scoreboard on the requester side,
// a vector table for arbitration and hand sequences for the multi-cycle cases.
module tb_sram_arbiter;

    localparam int unsigned RL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] p0_address, p1_address, mm_address;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [15:0] p0_writedata, p1_writedata, mm_writedata, mm_readdata;
    logic        p0_waitrequest, p1_waitrequest;
    logic [15:0] p0_readdata, p1_readdata;
    logic        p0_readdatavalid, p1_readdatavalid;
    logic        mm_read, mm_write;

    sram_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
        .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
        .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
        .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
        .mm_address(mm_address), .mm_read(mm_read), .mm_write(mm_write),
        .mm_writedata(mm_writedata), .mm_readdata(mm_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int mm_rd_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SRAM controller model: data for a read in cycle N appears in cycle N+RL
    logic [15:0] sram [logic [19:0]];
    logic [15:0] rd_pipe [RL];
    assign mm_readdata = rd_pipe[RL-1];

    always @(posedge clk) begin
        for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        if (mm_read) rd_pipe[0] <= sram.exists(mm_address) ? sram[mm_address] : 16'h0000;
        else rd_pipe[0] <= 16'hDEAD;
        if (mm_write) sram[mm_address] = mm_writedata;
    end

    // Reference memory and read scoreboard, fed only from requester-side handshakes
    typedef struct {
        logic        port;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [logic [19:0]];

    task automatic accept(input logic port, input logic rd, input logic [19:0] a, input logic [15:0] d);
        exp_t e;
        if (rd) begin
            e.port = port;
            e.data = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
            e.due  = cyc + int'(RL) + 1;
            sb.push_back(e);
        end else begin
            ref_mem[a] = d;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            sb.delete();
        end else begin
            if (mm_read || mm_write) chk("strobe_excl", 32'(mm_read & mm_write), 32'd0);
            if (mm_read) mm_rd_cnt++;
            if (p0_readdatavalid || p1_readdatavalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdv", 32'({p0_readdatavalid, p1_readdatavalid}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rdv_port", 32'({p0_readdatavalid, p1_readdatavalid}), e.port ? 32'd1 : 32'd2);
                    chk("rdv_cycle", 32'(cyc), 32'(e.due));
                    chk("rdv_data", 32'(e.port ? p1_readdata : p0_readdata), 32'(e.data));
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                chk("rdv_timeout", 32'({p0_readdatavalid, p1_readdatavalid}), sb[0].port ? 32'd1 : 32'd2);
                void'(sb.pop_front());
            end
            if (!p0_waitrequest && (p0_read || p0_write)) accept(1'b0, p0_read, p0_address, p0_writedata);
            if (!p1_waitrequest && (p1_read || p1_write)) accept(1'b1, p1_read, p1_address, p1_writedata);
        end
    end

    // Hold a request until accepted; checks the issued command and returns the stall count
    task automatic issue(input logic port, input logic rd, input logic wr,
                         input logic [19:0] a, input logic [15:0] d, output int waits);
        bit done = 0;
        if (port) begin p1_read = rd; p1_write = wr; p1_address = a; p1_writedata = d; end
        else      begin p0_read = rd; p0_write = wr; p0_address = a; p0_writedata = d; end
        waits = 0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (!(port ? p1_waitrequest : p0_waitrequest)) begin
                done = 1;
                chk("issue_mm_read", 32'(mm_read), 32'(rd));
                chk("issue_mm_write", 32'(mm_write), 32'(wr & ~rd));
                chk("issue_mm_address", 32'(mm_address), 32'(a));
                if (wr && !rd) chk("issue_mm_writedata", 32'(mm_writedata), 32'(d));
            end else begin
                waits++;
            end
        end
        if (!done) chk("issue_accept_timeout", 32'(port ? p1_waitrequest : p0_waitrequest), 32'd0);
        @(posedge clk); #1;
        if (port) begin p1_read = 1'b0; p1_write = 1'b0; end
        else      begin p0_read = 1'b0; p0_write = 1'b0; end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_pending", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        p0r, p0w;
        logic [19:0] p0a;
        logic [15:0] p0d;
        logic        p1r, p1w;
        logic [19:0] p1a;
        logic [15:0] p1d;
        logic        ew0, ew1, erd, ewr;
        logic [19:0] ea;
        logic [15:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic p0r, input logic p0w, input logic [19:0] p0a, input logic [15:0] p0d,
                                input logic p1r, input logic p1w, input logic [19:0] p1a, input logic [15:0] p1d,
                                input logic ew0, input logic ew1, input logic erd, input logic ewr,
                                input logic [19:0] ea, input logic [15:0] ed);
        vec_t v;
        v.p0r = p0r; v.p0w = p0w; v.p0a = p0a; v.p0d = p0d;
        v.p1r = p1r; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d;
        v.ew0 = ew0; v.ew1 = ew1; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        int   w;
        int   n0;
        int   n1;
        int   rd_before;
        bit   g1;

        // Starvation: both ports write continuously, grants p0 x4, p1, p0 x4, p1
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 10; i++) begin
            g1 = (i == 4) || (i == 9);
            vt.push_back(mk(1'b0, 1'b1, 20'(20'h00010 + n0), 16'(16'hA000 + n0),
                            1'b0, 1'b1, 20'h00100, 16'(16'hB000 + n1),
                            g1, !g1, 1'b0, 1'b1,
                            g1 ? 20'h00100 : 20'(20'h00010 + n0),
                            g1 ? 16'(16'hB000 + n1) : 16'(16'hA000 + n0)));
            if (g1) n1++; else n0++;
        end
        vt.push_back(mk(1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b1, 20'h00200, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b1, 20'h00200, 16'hC0DE));
        vt.push_back(mk(1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 1'b0, 20'h00200, 16'hC0DE, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00200, 16'hC0DE));
        vt.push_back(mk(1'b0, 1'b0, 20'h0, 16'h0, 1'b1, 1'b0, 20'h00200, 16'hC0DE, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00200, 16'hC0DE));
        vt.push_back(mk(1'b0, 1'b1, 20'h00300, 16'h3333, 1'b0, 1'b0, 20'h00200, 16'hC0DE, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00200, 16'hC0DE));
        vt.push_back(mk(1'b0, 1'b1, 20'h00300, 16'h3333, 1'b0, 1'b0, 20'h00200, 16'hC0DE, 1'b0, 1'b1, 1'b0, 1'b1, 20'h00300, 16'h3333));
        vt.push_back(mk(1'b1, 1'b0, 20'h00010, 16'h3333, 1'b1, 1'b0, 20'h00100, 16'h3333, 1'b0, 1'b1, 1'b1, 1'b0, 20'h00010, 16'h3333));
        vt.push_back(mk(1'b0, 1'b0, 20'h00010, 16'h3333, 1'b1, 1'b0, 20'h00100, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00010, 16'h3333));
        vt.push_back(mk(1'b0, 1'b0, 20'h00010, 16'h3333, 1'b1, 1'b0, 20'h00100, 16'h3333, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00100, 16'h3333));
        vt.push_back(mk(1'b0, 1'b0, 20'h00010, 16'h3333, 1'b0, 1'b0, 20'h00100, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00100, 16'h3333));
        vt.push_back(mk(1'b0, 1'b0, 20'h00010, 16'h3333, 1'b0, 1'b0, 20'h00100, 16'h3333, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00100, 16'h3333));

        // Reset hold with a pending port-0 read
        reset = 1'b1;
        p0_read = 1'b1; p0_write = 1'b0; p0_address = 20'h01234; p0_writedata = 16'h0;
        p1_read = 1'b0; p1_write = 1'b0; p1_address = 20'h0;     p1_writedata = 16'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_p0_wait", 32'(p0_waitrequest), 32'd1);
            chk("rst_mm_read", 32'(mm_read), 32'd0);
            chk("rst_rdv", 32'({p0_readdatavalid, p1_readdatavalid}), 32'd0);
            chk("rst_mm_address", 32'(mm_address), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        p0_read = 1'b0;

        // Port-0 write then read round trip
        issue(1'b0, 1'b0, 1'b1, 20'h01234, 16'hAAAA, w);
        chk("rt_write_wait", 32'(w), 32'd0);
        issue(1'b0, 1'b1, 1'b0, 20'h01234, 16'h0000, w);
        chk("rt_read_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("rt_busy_no_cmd", 32'({mm_read, mm_write}), 32'd0);
        @(posedge clk); #1;
        drain();

        // Tag routing: p1 read then p0 read back-to-back
        issue(1'b1, 1'b0, 1'b1, 20'h01235, 16'h5555, w);
        issue(1'b1, 1'b1, 1'b0, 20'h01235, 16'h0000, w);
        chk("tag_p1_wait", 32'(w), 32'd0);
        issue(1'b0, 1'b1, 1'b0, 20'h01234, 16'h0000, w);
        chk("tag_p0_wait", 32'(w), 32'd1);
        drain();

        // Reset one cycle after a read is issued
        issue(1'b0, 1'b1, 1'b0, 20'h01234, 16'h0000, w);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        issue(1'b1, 1'b0, 1'b1, 20'h00500, 16'h5050, w);
        chk("rst_mid_p1_wait", 32'(w), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rdv", 32'(p0_readdatavalid), 32'd0);
        end
        @(posedge clk); #1;

        // Simultaneous read and write on port 1
        issue(1'b1, 1'b0, 1'b1, 20'h00042, 16'h0BAD, w);
        rd_before = mm_rd_cnt;
        issue(1'b1, 1'b1, 1'b1, 20'h00042, 16'h4242, w);
        drain();
        chk("viol_single_read", 32'(mm_rd_cnt - rd_before), 32'd1);
        issue(1'b0, 1'b1, 1'b0, 20'h00042, 16'h0000, w);
        drain();

        // Clean starvation counter, then the vector table
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (vt[i]) begin
            p0_read = vt[i].p0r; p0_write = vt[i].p0w; p0_address = vt[i].p0a; p0_writedata = vt[i].p0d;
            p1_read = vt[i].p1r; p1_write = vt[i].p1w; p1_address = vt[i].p1a; p1_writedata = vt[i].p1d;
            @(negedge clk);
            chk($sformatf("vec%0d_p0_wait", i), 32'(p0_waitrequest), 32'(vt[i].ew0));
            chk($sformatf("vec%0d_p1_wait", i), 32'(p1_waitrequest), 32'(vt[i].ew1));
            chk($sformatf("vec%0d_mm_read", i), 32'(mm_read), 32'(vt[i].erd));
            chk($sformatf("vec%0d_mm_write", i), 32'(mm_write), 32'(vt[i].ewr));
            chk($sformatf("vec%0d_mm_address", i), 32'(mm_address), 32'(vt[i].ea));
            chk($sformatf("vec%0d_mm_writedata", i), 32'(mm_writedata), 32'(vt[i].ed));
            @(posedge clk); #1;
        end
        p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
